// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default register-file geometry and the
// reset-value function used to preload the register array.
package pipeline_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    // Register i resets to i in test-value mode, otherwise to zero; callers truncate.
    function automatic logic [63:0] regfile_reset_val(input int index, input int resetIndex);
        return (resetIndex != 0) ? 64'(index) : 64'd0;
    endfunction

endpackage

// File: rtl/regfile_sb_bits.sv
// Per-register busy scoreboard: writes clear, reservations set (set wins),
// with optional hardwired-zero masking of bit 0.
module regfile_sb_bits
    import pipeline_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr1_en,
    input  logic [ADDR_W-1:0]        clr1_addr,
    input  logic                     clr2_en,
    input  logic [ADDR_W-1:0]        clr2_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [(1<<ADDR_W)-1:0]   busy_vec,
    output logic                     rd_busy1,
    output logic                     rd_busy2
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DEPTH-1:0] KEEP_MASK =
        (ZERO_REG != 0) ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] clrMask;
    logic [DEPTH-1:0] setMask;
    logic [DEPTH-1:0] readView;

    always_comb begin
        clrMask = '0;
        setMask = '0;
        if (clr1_en) clrMask[clr1_addr] = 1'b1;
        if (clr2_en) clrMask[clr2_addr] = 1'b1;
        if (rsv_en)  setMask[rsv_addr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= ((busy & ~clrMask) | setMask) & KEEP_MASK;
    end

    // Readers see a same-cycle writeback as already retired when bypass is on.
    assign readView = (BYPASS != 0) ? (busy & ~clrMask) : busy;
    assign busy_vec = busy;
    assign rd_busy1 = readView[rd_addr1];
    assign rd_busy2 = readView[rd_addr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage 2-read/2-write register file with optional write bypass,
// hardwired-zero register and a busy scoreboard for hazard detection.
module regfile_scoreboard
    import pipeline_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 0,
    parameter int RESET_INDEX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [DATA_W-1:0]        rd_data1,
    output logic [DATA_W-1:0]        rd_data2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     wr2_en,
    input  logic [ADDR_W-1:0]        wr_addr2,
    input  logic [DATA_W-1:0]        wr_data2,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DATA_W-1:0]        top_reg,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_IDX = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] regs [DEPTH];
    logic              we1;
    logic              we2;

    // Writes aimed at a hardwired zero register are dropped at the source.
    assign we1 = wr_en && !((ZERO_REG != 0) && (wr_addr1 == '0));
    assign we2 = wr_en && wr2_en && !((ZERO_REG != 0) && (wr_addr2 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= DATA_W'(regfile_reset_val(i, RESET_INDEX));
        end else begin
            if (we1) regs[wr_addr1] <= wr_data1;
            if (we2) regs[wr_addr2] <= wr_data2;
        end
    end

    // Port 2 is checked first so it wins a dual address match.
    function automatic logic [DATA_W-1:0] readPort(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              en1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1,
        input logic              en2,
        input logic [ADDR_W-1:0] a2,
        input logic [DATA_W-1:0] d2
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (BYPASS != 0) begin
            if (en2 && (addr == a2))      val = d2;
            else if (en1 && (addr == a1)) val = d1;
        end
        if ((ZERO_REG != 0) && (addr == '0)) val = '0;
        return val;
    endfunction

    assign rd_data1 = readPort(rd_addr1, regs[rd_addr1], we1, wr_addr1, wr_data1,
                               we2, wr_addr2, wr_data2);
    assign rd_data2 = readPort(rd_addr2, regs[rd_addr2], we1, wr_addr1, wr_data1,
                               we2, wr_addr2, wr_data2);
    assign top_reg  = readPort(TOP_IDX, regs[TOP_IDX], we1, wr_addr1, wr_data1,
                               we2, wr_addr2, wr_data2);

    regfile_sb_bits #(
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .clr1_en   (we1),
        .clr1_addr (wr_addr1),
        .clr2_en   (we2),
        .clr2_addr (wr_addr2),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .busy_vec  (busy_vec),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: three configurations driven in parallel
// (bypass, hardwired zero, no bypass) with directed and random scoreboard tests.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr1, wr_addr2, rsv_addr;
    logic [15:0] wr_data1, wr_data2;
    logic        wr_en, wr2_en, rsv_en;

    logic [15:0] d1A, d2A, topA, bvA;
    logic        b1A, b2A;
    logic [15:0] d1Z, d2Z, topZ, bvZ;
    logic        b1Z, b2Z;
    logic [15:0] d1N, d2N, topN, bvN;
    logic        b1N, b2N;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d1, d2, top, busy, n1;
    } exp_t;
    exp_t expQ[$];

    logic [15:0] mRegs [16];
    logic [15:0] mBusy;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0), .RESET_INDEX(1)) dut (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1A), .rd_data2(d2A), .rd_busy1(b1A), .rd_busy2(b2A),
        .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr2_en(wr2_en), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .top_reg(topA), .busy_vec(bvA));

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1), .RESET_INDEX(1)) dutZ (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1Z), .rd_data2(d2Z), .rd_busy1(b1Z), .rd_busy2(b2Z),
        .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr2_en(wr2_en), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .top_reg(topZ), .busy_vec(bvZ));

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(0), .RESET_INDEX(1)) dutN (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1N), .rd_data2(d2N), .rd_busy1(b1N), .rd_busy2(b2N),
        .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr2_en(wr2_en), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .top_reg(topN), .busy_vec(bvN));

    task automatic idle();
        wr_en = 0; wr2_en = 0; rsv_en = 0;
        wr_addr1 = 0; wr_addr2 = 0; rsv_addr = 0;
        wr_data1 = 0; wr_data2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); rd_addr1 = 7; rd_addr2 = 0;
        tick();
        rst = 0;
        #1;
        checks++; if (d1A !== 16'h0007) begin errors++; $display("FAIL reset_rd7 got %h exp 0007", d1A); end
        checks++; if (topA !== 16'h000F) begin errors++; $display("FAIL reset_top got %h exp 000f", topA); end
        checks++; if (bvA !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", bvA); end
        checks++; if (d2Z !== 16'h0000) begin errors++; $display("FAIL reset_zero_rd0 got %h exp 0000", d2Z); end
    endtask

    task automatic test_collision_bypass();
        wr_en = 1; wr2_en = 1; wr_addr1 = 3; wr_addr2 = 3;
        wr_data1 = 16'hAAAA; wr_data2 = 16'h5555; rd_addr1 = 3;
        #1;
        checks++; if (d1A !== 16'h5555) begin errors++; $display("FAIL coll_bypass got %h exp 5555", d1A); end
        checks++; if (d1N !== 16'h0003) begin errors++; $display("FAIL coll_nobyp_old got %h exp 0003", d1N); end
        tick();
        idle();
        #1;
        checks++; if (d1A !== 16'h5555) begin errors++; $display("FAIL coll_stored got %h exp 5555", d1A); end
        checks++; if (d1N !== 16'h5555) begin errors++; $display("FAIL coll_stored_n got %h exp 5555", d1N); end
        // wr2_en alone must not write
        wr_en = 0; wr2_en = 1; wr_addr2 = 9; wr_data2 = 16'h1111; rd_addr2 = 9;
        #1;
        checks++; if (d2A !== 16'h0009) begin errors++; $display("FAIL wr2_only_byp got %h exp 0009", d2A); end
        tick();
        idle();
        #1;
        checks++; if (d2A !== 16'h0009) begin errors++; $display("FAIL wr2_only_store got %h exp 0009", d2A); end
        // top register bypass
        wr_en = 1; wr_addr1 = 15; wr_data1 = 16'hCAFE;
        #1;
        checks++; if (topA !== 16'hCAFE) begin errors++; $display("FAIL top_bypass got %h exp cafe", topA); end
        checks++; if (topN !== 16'h000F) begin errors++; $display("FAIL top_nobyp got %h exp 000f", topN); end
        tick();
        idle();
        #1;
        checks++; if (topN !== 16'hCAFE) begin errors++; $display("FAIL top_stored got %h exp cafe", topN); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_addr = 5; rd_addr1 = 5;
        tick();
        idle();
        #1;
        checks++; if (bvA[5] !== 1'b1) begin errors++; $display("FAIL rsv_set got %b exp 1", bvA[5]); end
        checks++; if (b1A !== 1'b1) begin errors++; $display("FAIL rsv_rdbusy got %b exp 1", b1A); end
        wr_en = 1; wr_addr1 = 5; wr_data1 = 16'h0055; rsv_en = 1; rsv_addr = 5;
        tick();
        idle();
        #1;
        checks++; if (bvA[5] !== 1'b1) begin errors++; $display("FAIL rsv_wins got %b exp 1", bvA[5]); end
        wr_en = 1; wr_addr1 = 5; wr_data1 = 16'h0056;
        #1;
        checks++; if (b1A !== 1'b0) begin errors++; $display("FAIL clr_bypass got %b exp 0", b1A); end
        checks++; if (b1N !== 1'b1) begin errors++; $display("FAIL clr_nobyp got %b exp 1", b1N); end
        tick();
        idle();
        #1;
        checks++; if (bvA !== 16'h0000) begin errors++; $display("FAIL clr_done got %h exp 0000", bvA); end
        // double reserve, single write clears; write to idle reg stays clear
        rsv_en = 1; rsv_addr = 6;
        tick(); tick();
        idle();
        wr_en = 1; wr2_en = 1; wr_addr1 = 6; wr_addr2 = 7; wr_data1 = 16'h0066; wr_data2 = 16'h0077;
        tick();
        idle();
        #1;
        checks++; if (bvA !== 16'h0000) begin errors++; $display("FAIL no_count got %h exp 0000", bvA); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1; wr_addr1 = 0; wr_data1 = 16'h1234; rsv_en = 1; rsv_addr = 0; rd_addr1 = 0;
        #1;
        checks++; if (d1Z !== 16'h0000) begin errors++; $display("FAIL zero_byp got %h exp 0000", d1Z); end
        checks++; if (b1Z !== 1'b0) begin errors++; $display("FAIL zero_busy_pre got %b exp 0", b1Z); end
        tick();
        idle();
        #1;
        checks++; if (d1Z !== 16'h0000) begin errors++; $display("FAIL zero_store got %h exp 0000", d1Z); end
        checks++; if (bvZ[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", bvZ[0]); end
        checks++; if (d1A !== 16'h1234) begin errors++; $display("FAIL nonzero_r0 got %h exp 1234", d1A); end
        checks++; if (bvA[0] !== 1'b1) begin errors++; $display("FAIL nonzero_busy0 got %b exp 1", bvA[0]); end
    endtask

    task automatic test_no_bypass();
        wr_en = 1; wr_addr1 = 2; wr_data1 = 16'hBEEF; rd_addr1 = 2;
        #1;
        checks++; if (d1N !== 16'h0002) begin errors++; $display("FAIL nobyp_old got %h exp 0002", d1N); end
        checks++; if (d1A !== 16'hBEEF) begin errors++; $display("FAIL byp_new got %h exp beef", d1A); end
        tick();
        idle();
        #1;
        checks++; if (d1N !== 16'hBEEF) begin errors++; $display("FAIL nobyp_new got %h exp beef", d1N); end
    endtask

    function automatic logic [15:0] mRead(input logic [3:0] a);
        if (wr_en && wr2_en && a == wr_addr2) return wr_data2;
        if (wr_en && a == wr_addr1) return wr_data1;
        return mRegs[a];
    endfunction

    task automatic test_random();
        exp_t e;
        logic [15:0] clr, set;
        rst = 1; idle();
        tick();
        rst = 0;
        for (int i = 0; i < 16; i++) mRegs[i] = 16'(i);
        mBusy = '0;
        for (int c = 0; c < 60; c++) begin
            wr_en = 1'($urandom_range(0, 1)); wr2_en = 1'($urandom_range(0, 1));
            rsv_en = 1'($urandom_range(0, 1));
            wr_addr1 = 4'($urandom_range(0, 15)); wr_addr2 = 4'($urandom_range(0, 15));
            rsv_addr = 4'($urandom_range(0, 15));
            rd_addr1 = 4'($urandom_range(0, 15)); rd_addr2 = 4'($urandom_range(0, 15));
            wr_data1 = 16'($urandom); wr_data2 = 16'($urandom);
            e.d1 = mRead(rd_addr1); e.d2 = mRead(rd_addr2); e.top = mRead(4'hF);
            e.busy = mBusy; e.n1 = mRegs[rd_addr1];
            expQ.push_back(e);
            #1;
            e = expQ.pop_front();
            checks++; if (d1A !== e.d1) begin errors++; $display("FAIL rnd_rd1 cyc %0d got %h exp %h", c, d1A, e.d1); end
            checks++; if (d2A !== e.d2) begin errors++; $display("FAIL rnd_rd2 cyc %0d got %h exp %h", c, d2A, e.d2); end
            checks++; if (topA !== e.top) begin errors++; $display("FAIL rnd_top cyc %0d got %h exp %h", c, topA, e.top); end
            checks++; if (bvA !== e.busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %h exp %h", c, bvA, e.busy); end
            checks++; if (d1N !== e.n1) begin errors++; $display("FAIL rnd_nobyp cyc %0d got %h exp %h", c, d1N, e.n1); end
            clr = '0; set = '0;
            if (wr_en) begin mRegs[wr_addr1] = wr_data1; clr[wr_addr1] = 1'b1; end
            if (wr_en && wr2_en) begin mRegs[wr_addr2] = wr_data2; clr[wr_addr2] = 1'b1; end
            if (rsv_en) set[rsv_addr] = 1'b1;
            mBusy = (mBusy & ~clr) | set;
            tick();
        end
        idle();
    endtask

    task automatic test_reset_during_write();
        rsv_en = 1; rsv_addr = 9;
        tick();
        rst = 1; rsv_en = 1; rsv_addr = 4;
        wr_en = 1; wr_addr1 = 4; wr_data1 = 16'hFFFF; rd_addr1 = 4;
        tick();
        rst = 0; idle();
        #1;
        checks++; if (d1A !== 16'h0004) begin errors++; $display("FAIL rstwr_data got %h exp 0004", d1A); end
        checks++; if (bvA !== 16'h0000) begin errors++; $display("FAIL rstwr_busy got %h exp 0000", bvA); end
        checks++; if (d1N !== 16'h0004) begin errors++; $display("FAIL rstwr_data_n got %h exp 0004", d1N); end
        checks++; if (bvZ !== 16'h0000) begin errors++; $display("FAIL rstwr_busy_z got %h exp 0000", bvZ); end
    endtask

    initial begin
        rst = 1; idle(); rd_addr1 = 0; rd_addr2 = 0;
        test_reset();
        test_collision_bypass();
        test_scoreboard();
        test_zero_reg();
        test_no_bypass();
        test_random();
        test_reset_during_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
